// File: rtl/hdlc_pkg.sv
// Shared HDLC definitions for the Tx and Rx channels.
package hdlc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START_FLAG,
        DATA,
        FCS,
        END_FLAG,
        ABORT
    } tx_state_t;

    localparam logic [7:0]  HDLC_FLAG     = 8'h7E;
    localparam logic [7:0]  HDLC_ABORT    = 8'hFE;
    localparam logic [15:0] HDLC_FCS_POLY = 16'hA001;

    // One step of the reflected serial CRC-16.
    function automatic logic [15:0] fcs_step(input logic [15:0] crc, input logic din,
                                             input logic [15:0] poly);
        logic fb;
        fb = crc[0] ^ din;
        return (crc >> 1) ^ (fb ? poly : 16'h0000);
    endfunction

endpackage

// File: rtl/hdlc_fcs_gen.sv
// Serial reflected CRC-16 generator; clr has priority over en.
module hdlc_fcs_gen
    import hdlc_pkg::*;
#(
    parameter logic [15:0] POLY = HDLC_FCS_POLY
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        en,
    input  logic        din,
    output logic [15:0] crc
);

    // CRC register: cleared while idle, advanced one bit per enabled cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc <= 16'h0000;
        end else if (clr) begin
            crc <= 16'h0000;
        end else if (en) begin
            crc <= fcs_step(crc, din, POLY);
        end
    end

endmodule

// File: rtl/hdlc_tx_channel.sv
// HDLC transmit bit engine: flags, bit stuffing, FCS append and abort.
// state_q/bit_idx_q/stuff_q always describe the bit currently on Tx.
module hdlc_tx_channel
    import hdlc_pkg::*;
#(
    parameter int unsigned FRAME_MAX = 126,
    parameter logic [15:0] FCS_POLY  = HDLC_FCS_POLY
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       Tx_ValidFrame,
    input  logic [7:0] Tx_FrameSize,
    input  logic [7:0] Tx_Data,
    input  logic       Tx_AbortFrame,
    output logic       Tx_RdBuff,
    output logic       Tx,
    output logic       TxEN,
    output logic       Tx_Done,
    output logic       Tx_AbortedTrans
);

    localparam logic [7:0] MaxSize = 8'(FRAME_MAX);

    tx_state_t   state_q, state_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [2:0]  ones_q, ones_d;
    logic [7:0]  byte_idx_q, byte_idx_d;
    logic [7:0]  size_q, size_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  hold_q, next_byte, last_idx;
    logic        tx_q, tx_d;
    logic        stuff_q, stuff_d;
    logic        aborted_q, aborted_d;
    logic        rd_q, rd_buff;
    logic        stuffable, crc_en, need_stuff;
    logic [15:0] crc_q, crc_nxt;

    hdlc_fcs_gen #(
        .POLY (FCS_POLY)
    ) u_fcs (
        .clk   (Clk),
        .rst_n (Rst),
        .clr   (state_q == IDLE),
        .en    (crc_en),
        .din   (tx_q),
        .crc   (crc_q)
    );

    // Fetch request, CRC enable and stuffing decision for the bit now on Tx.
    always_comb begin
        last_idx   = size_q - 8'd1;
        next_byte  = rd_q ? Tx_Data : hold_q;
        stuffable  = (state_q == DATA) || (state_q == FCS);
        // FCS bits are shifted out by feeding the register its own LSB.
        crc_en     = stuffable && !stuff_q;
        crc_nxt    = crc_en ? fcs_step(crc_q, tx_q, FCS_POLY) : crc_q;
        need_stuff = stuffable && !stuff_q && tx_q && (ones_q == 3'd4);
        rd_buff    = 1'b0;
        if (!stuff_q && bit_idx_q == 3'd6) begin
            if (state_q == START_FLAG) begin
                rd_buff = 1'b1;
            end else if (state_q == DATA && byte_idx_q != last_idx) begin
                rd_buff = 1'b1;
            end
        end
    end

    // Next-state logic: choose the next bit to place on Tx.
    always_comb begin
        state_d    = state_q;
        bit_idx_d  = bit_idx_q;
        byte_idx_d = byte_idx_q;
        size_d     = size_q;
        shift_d    = shift_q;
        tx_d       = tx_q;
        stuff_d    = 1'b0;
        ones_d     = ones_q;
        aborted_d  = 1'b0;
        case (state_q)
            IDLE: begin
                tx_d   = 1'b1;
                ones_d = 3'd0;
                if (Tx_ValidFrame && Tx_FrameSize != 8'd0) begin
                    state_d    = START_FLAG;
                    size_d     = (Tx_FrameSize > MaxSize) ? MaxSize : Tx_FrameSize;
                    shift_d    = HDLC_FLAG;
                    tx_d       = HDLC_FLAG[0];
                    bit_idx_d  = 3'd0;
                    byte_idx_d = 8'd0;
                end
            end
            ABORT: begin
                if (bit_idx_q == 3'd7) begin
                    state_d   = IDLE;
                    tx_d      = 1'b1;
                    aborted_d = 1'b1;
                end else begin
                    bit_idx_d = bit_idx_q + 3'd1;
                    shift_d   = shift_q >> 1;
                    tx_d      = shift_q[1];
                end
            end
            default: begin
                if (Tx_AbortFrame && state_q != END_FLAG) begin
                    state_d   = ABORT;
                    shift_d   = HDLC_ABORT;
                    tx_d      = HDLC_ABORT[0];
                    bit_idx_d = 3'd0;
                    ones_d    = 3'd0;
                end else if (need_stuff) begin
                    tx_d    = 1'b0;
                    stuff_d = 1'b1;
                    ones_d  = 3'd0;
                end else begin
                    ones_d = (stuffable && !stuff_q && tx_q) ? ones_q + 3'd1 : 3'd0;
                    if (bit_idx_q != 3'd7) begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        shift_d   = shift_q >> 1;
                        tx_d      = (state_q == FCS) ? crc_nxt[0] : shift_q[1];
                    end else begin
                        bit_idx_d = 3'd0;
                        case (state_q)
                            START_FLAG: begin
                                state_d    = DATA;
                                byte_idx_d = 8'd0;
                                shift_d    = next_byte;
                                tx_d       = next_byte[0];
                            end
                            DATA: begin
                                if (byte_idx_q == last_idx) begin
                                    state_d    = FCS;
                                    byte_idx_d = 8'd0;
                                    tx_d       = crc_nxt[0];
                                end else begin
                                    byte_idx_d = byte_idx_q + 8'd1;
                                    shift_d    = next_byte;
                                    tx_d       = next_byte[0];
                                end
                            end
                            FCS: begin
                                if (byte_idx_q == 8'd1) begin
                                    state_d = END_FLAG;
                                    shift_d = HDLC_FLAG;
                                    tx_d    = HDLC_FLAG[0];
                                end else begin
                                    byte_idx_d = 8'd1;
                                    tx_d       = crc_nxt[0];
                                end
                            end
                            END_FLAG: begin
                                state_d = IDLE;
                                tx_d    = 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q    <= IDLE;
            bit_idx_q  <= 3'd0;
            ones_q     <= 3'd0;
            byte_idx_q <= 8'd0;
            size_q     <= 8'd0;
            shift_q    <= 8'd0;
            hold_q     <= 8'd0;
            tx_q       <= 1'b1;
            stuff_q    <= 1'b0;
            aborted_q  <= 1'b0;
            rd_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_idx_q  <= bit_idx_d;
            ones_q     <= ones_d;
            byte_idx_q <= byte_idx_d;
            size_q     <= size_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            stuff_q    <= stuff_d;
            aborted_q  <= aborted_d;
            rd_q       <= rd_buff;
            if (rd_q) begin
                hold_q <= Tx_Data;
            end
        end
    end

    assign Tx_RdBuff       = rd_buff;
    assign Tx              = tx_q;
    assign TxEN            = (state_q != IDLE);
    assign Tx_Done         = (state_q == IDLE);
    assign Tx_AbortedTrans = aborted_q;

endmodule
